unpool2_stream: RTL and testbench

//   Streaming 2x2 nearest-neighbour unpool (upsample): the inverse of the 2x2 pooling stage.

---
 rtl/unpool2_stream_if.sv | 30 +++
 rtl/unpool2_stream.sv | 145 ++++++++++++++
 tb/tb_unpool2_stream.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/unpool2_stream_if.sv
// Stream bundle for the 2x2 unpool stage.
// Carries the pooled-pixel input stream (valid/ready/data), the upsampled
// output stream (valid/ready/data plus sof/eol/eof sideband) and the
// end-of-frame pulse.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : unpool block side (drives in_ready, out_*, frame_done)
interface unpool2_stream_if #(
  parameter int BW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof, frame_done
  );
endinterface

// File: rtl/unpool2_stream.sv
// Streaming 2x2 nearest-neighbour unpool.
// Buffers one IN_W-pixel input row, then replays it as two output rows
// (EMIT0, EMIT1), each buffered pixel repeated twice per row.  When an
// output dimension is odd the last column / last input row is emitted once.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous reset, active-low
//   bus  : unpool2_stream_if.slave -- in_valid/in_ready/in_data input stream,
//          out_valid/out_ready/out_data/out_sof/out_eol/out_eof output stream,
//          frame_done one-cycle pulse after the out_eof handshake
module unpool2_stream #(
  parameter int BW    = 8,
  parameter int IN_W  = 13,
  parameter int IN_H  = 13,
  parameter int OUT_W = 25,
  parameter int OUT_H = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  unpool2_stream_if.slave      bus
);

  localparam int CW  = $clog2(IN_W);
  localparam int RW  = $clog2(IN_H);
  localparam int OW  = $clog2(OUT_W);
  localparam int ORW = RW + 1;

  localparam logic [CW-1:0]  IN_COL_LAST  = CW'(IN_W - 1);
  localparam logic [RW-1:0]  IN_ROW_LAST  = RW'(IN_H - 1);
  localparam logic [OW-1:0]  OUT_COL_LAST = OW'(OUT_W - 1);
  localparam logic [ORW-1:0] OUT_ROW_LAST = ORW'(OUT_H - 1);

  typedef enum logic [1:0] {LOAD, EMIT0, EMIT1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   in_col;
  logic [RW-1:0]   in_row;
  logic [OW-1:0]   out_col;
  logic            frame_done_r;
  logic [BW-1:0]   linebuf [IN_W];

  logic            in_ready_c;
  logic            out_valid_c;
  logic            in_fire;
  logic            out_fire;
  logic            row_end;
  logic            odd_row_exists;
  logic            row_complete;
  logic            eol_c;
  logic            eof_c;
  logic            sof_c;
  logic [ORW-1:0]  out_row;
  logic [CW-1:0]   rd_idx;

  assign in_fire  = bus.in_valid & in_ready_c;
  assign out_fire = out_valid_c & bus.out_ready;
  assign row_end  = out_fire & (out_col == OUT_COL_LAST);

  // Output row index is 2*in_row in EMIT0 and 2*in_row+1 in EMIT1.
  assign out_row = {in_row, (state == EMIT1)};

  // The odd output row of this input row exists unless OUT_H is odd and
  // this is the last input row (cropped).
  assign odd_row_exists = ({in_row, 1'b1} <= OUT_ROW_LAST);
  assign row_complete   = row_end & ((state == EMIT1) | ~odd_row_exists);

  assign rd_idx = CW'(out_col >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && (in_col == IN_COL_LAST)) state_nxt = EMIT0;
      EMIT0:   if (row_end) state_nxt = odd_row_exists ? EMIT1 : LOAD;
      EMIT1:   if (row_end) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    sof_c       = 1'b0;
    case (state)
      LOAD:    in_ready_c = rst;
      EMIT0: begin
        out_valid_c = 1'b1;
        sof_c       = (in_row == '0) && (out_col == '0);
      end
      EMIT1:   out_valid_c = 1'b1;
      default: ;
    endcase
    eol_c = out_valid_c && (out_col == OUT_COL_LAST);
    eof_c = eol_c && (out_row == OUT_ROW_LAST);
  end

  // Position counters and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_col       <= '0;
      in_row       <= '0;
      out_col      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= out_fire & eof_c;
      if (in_fire) begin
        in_col <= (in_col == IN_COL_LAST) ? '0 : in_col + 1'b1;
      end
      if (out_fire) begin
        out_col <= row_end ? '0 : out_col + 1'b1;
      end
      if (row_complete) begin
        in_row <= (in_row == IN_ROW_LAST) ? '0 : in_row + 1'b1;
      end
    end
  end

  // Line buffer: data only, never reset; writes gated by in_fire, which is
  // already suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      linebuf[in_col] <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = linebuf[rd_idx];
  assign bus.out_sof    = sof_c;
  assign bus.out_eol    = eol_c;
  assign bus.out_eof    = eof_c;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_unpool2_stream.sv
// Bench for unpool2_stream: default 13x13->25x25 instance (a) and an even
// 4x4->8x8 instance (b). Expected outputs come from out(r,c) = in(r>>1,c>>1).
module tb_unpool2_stream;

  localparam int A_IW = 13, A_IH = 13, A_OW = 25, A_OH = 25;
  localparam int A_NIN  = A_IW * A_IH;
  localparam int A_NOUT = A_OW * A_OH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] frame_a [A_NIN];

  unpool2_stream_if #(.BW(8)) a_if ();
  unpool2_stream_if #(.BW(8)) b_if ();

  unpool2_stream #(.BW(8), .IN_W(A_IW), .IN_H(A_IH), .OUT_W(A_OW), .OUT_H(A_OH))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));

  unpool2_stream #(.BW(8), .IN_W(4), .IN_H(4), .OUT_W(8), .OUT_H(8))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Streams frame_a through instance a. abort_at > 0 stops after that many
  // output handshakes (the last one is left for the caller to cancel).
  task automatic run_a(input int gap_pct, input int rdy_pct, input int abort_at);
    int in_idx = 0, out_idx = 0, cyc = 0, sof_n = 0, eol_n = 0;
    int r, c;
    bit prev_stall = 0, prev_eof_fire = 0, prev_row_load = 0;
    bit in_fire, out_fire, aborted = 0;
    logic [7:0] held_d = '0;
    logic [2:0] held_f = '0;
    logic [7:0] exp_d;
    while (out_idx < A_NOUT && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_data", a_if.out_data, held_d);
        chk("stall_flags", {a_if.out_sof, a_if.out_eol, a_if.out_eof}, held_f);
      end
      chk("frame_done_idle", a_if.frame_done, 1'b0);
      if (prev_row_load) chk("latency_out_valid", a_if.out_valid, 1'b1);
      a_if.in_valid  = (in_idx < A_NIN) && ($urandom_range(99) >= gap_pct);
      a_if.in_data   = frame_a[(in_idx < A_NIN) ? in_idx : 0];
      a_if.out_ready = ($urandom_range(99) < rdy_pct);
      in_fire  = a_if.in_valid && a_if.in_ready;
      out_fire = a_if.out_valid && a_if.out_ready;
      prev_row_load = in_fire && ((in_idx % A_IW) == A_IW - 1);
      if (in_fire) in_idx++;
      prev_stall = a_if.out_valid && !a_if.out_ready;
      held_d = a_if.out_data;
      held_f = {a_if.out_sof, a_if.out_eol, a_if.out_eof};
      prev_eof_fire = 0;
      if (out_fire) begin
        r = out_idx / A_OW;
        c = out_idx % A_OW;
        exp_d = frame_a[(r >> 1) * A_IW + (c >> 1)];
        chk($sformatf("data(%0d,%0d)", r, c), a_if.out_data, exp_d);
        chk("sof", a_if.out_sof, out_idx == 0);
        chk("eol", a_if.out_eol, c == A_OW - 1);
        chk("eof", a_if.out_eof, out_idx == A_NOUT - 1);
        if (a_if.out_sof) sof_n++;
        if (a_if.out_eol) eol_n++;
        prev_eof_fire = (out_idx == A_NOUT - 1);
        if (r == 24 && c == 24) chk("crop_out_24_24", a_if.out_data, frame_a[A_NIN - 1]);
        out_idx++;
        if (out_idx == abort_at) begin
          aborted = 1;
          break;
        end
      end
    end
    if (!aborted) begin
      chk("out_count", out_idx, A_NOUT);
      chk("sof_count", sof_n, 1);
      chk("eol_count", eol_n, A_OW);
      @(negedge clk);
      chk("frame_done_pulse", a_if.frame_done, prev_eof_fire);
      chk("in_ready_after_eof", a_if.in_ready, 1'b1);
      a_if.in_valid  = 1'b0;
      a_if.out_ready = 1'b0;
      @(negedge clk);
      chk("frame_done_single", a_if.frame_done, 1'b0);
    end
  endtask

  task automatic run_b();
    int in_idx = 0, n = 0, cyc = 0, r, c, k;
    int seen [16];
    logic [7:0] d;
    foreach (seen[i]) seen[i] = 0;
    while (n < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      b_if.in_valid  = (in_idx < 16);
      b_if.in_data   = 8'(16 * (in_idx / 4) + (in_idx % 4));
      b_if.out_ready = 1'b1;
      if (b_if.in_valid && b_if.in_ready) in_idx++;
      if (b_if.out_valid) begin
        r = n / 8;
        c = n % 8;
        d = b_if.out_data;
        chk("b_data", d, 8'(16 * (r >> 1) + (c >> 1)));
        chk("b_eof", b_if.out_eof, n == 63);
        k = (d >> 4) * 4 + (d & 8'h0f);
        if (k < 16) seen[k]++;
        if (n == 63) chk("b_out_7_7", d, 8'h33);
        n++;
      end
    end
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b0;
    chk("b_out_count", n, 64);
    for (int i = 0; i < 16; i++) chk($sformatf("b_repl_%0d", i), seen[i], 4);
  endtask

  initial begin
    a_if.in_valid = 1'b1; a_if.in_data = 8'h5a; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b1; b_if.in_data = 8'ha5; b_if.out_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", a_if.in_ready, 1'b0);
      chk("rst_out_valid", a_if.out_valid, 1'b0);
      chk("rst_frame_done", a_if.frame_done, 1'b0);
      chk("rst_b_in_ready", b_if.in_ready, 1'b0);
    end
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", a_if.in_ready, 1'b1);
    chk("post_rst_out_valid", a_if.out_valid, 1'b0);

    // Full-rate frame with ramp data
    for (int i = 0; i < A_NIN; i++) frame_a[i] = 8'((i / A_IW) * A_IW + (i % A_IW));
    run_a(0, 100, 0);
    // Same frame with input gaps and output back-pressure
    run_a(30, 50, 0);

    // Even configuration
    run_b();

    // Abort inside EMIT1 of input row 5 (output row 11, col 4), then reset
    for (int i = 0; i < A_NIN; i++) frame_a[i] = 8'($urandom);
    run_a(20, 100, 11 * A_OW + 5);
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_out_valid", a_if.out_valid, 1'b0);
    @(negedge clk);
    chk("abort_in_ready", a_if.in_ready, 1'b1);
    for (int i = 0; i < A_NIN; i++) frame_a[i] = 8'($urandom);
    run_a(10, 70, 0);
    // Back-to-back frame
    for (int i = 0; i < A_NIN; i++) frame_a[i] = 8'($urandom);
    run_a(0, 100, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
